mc_control_unit: RTL

//  Multi-cycle control FSM for the 16-bit TSC datapath: the initiator that drives the ALU's func code and operand selects.

---
 rtl/mc_control_unit_pkg.sv | 108 ++++++++++
 rtl/mc_control_unit_instr_decoder.sv | 95 +++++++++
 rtl/mc_control_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mc_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit of the 16-bit TSC CPU.
// Holds the instruction opcodes and R-type func fields, the ALU func codes driven
// on alu_func, the FSM state encoding, the datapath select codes and the decoded
// instruction class record produced by the instruction decoder.
package mc_control_unit_pkg;

  localparam int DEF_WORD_SIZE = 16;

  // Instruction opcodes (instr[15:12])
  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  // R-type func field (instr[5:0])
  localparam logic [5:0] INST_FUNC_ADD = 6'd0;
  localparam logic [5:0] INST_FUNC_SUB = 6'd1;
  localparam logic [5:0] INST_FUNC_AND = 6'd2;
  localparam logic [5:0] INST_FUNC_ORR = 6'd3;
  localparam logic [5:0] INST_FUNC_NOT = 6'd4;
  localparam logic [5:0] INST_FUNC_TCP = 6'd5;
  localparam logic [5:0] INST_FUNC_SHL = 6'd6;
  localparam logic [5:0] INST_FUNC_SHR = 6'd7;
  localparam logic [5:0] INST_FUNC_JPR = 6'd25;
  localparam logic [5:0] INST_FUNC_JRL = 6'd26;
  localparam logic [5:0] INST_FUNC_WWD = 6'd28;
  localparam logic [5:0] INST_FUNC_HLT = 6'd29;

  // ALU func codes driven on alu_func
  localparam logic [3:0] FUNC_ADD = 4'd0;
  localparam logic [3:0] FUNC_SUB = 4'd1;
  localparam logic [3:0] FUNC_AND = 4'd2;
  localparam logic [3:0] FUNC_ORR = 4'd3;
  localparam logic [3:0] FUNC_NOT = 4'd4;
  localparam logic [3:0] FUNC_TCP = 4'd5;
  localparam logic [3:0] FUNC_SHL = 4'd6;
  localparam logic [3:0] FUNC_SHR = 4'd7;
  localparam logic [3:0] FUNC_LHI = 4'd8;
  localparam logic [3:0] FUNC_BNE = 4'd9;
  localparam logic [3:0] FUNC_BEQ = 4'd10;
  localparam logic [3:0] FUNC_BGZ = 4'd11;
  localparam logic [3:0] FUNC_BLZ = 4'd12;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_HLT = 3'd5
  } state_t;

  // pc_src
  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REG    = 2'd3;
  // alu_src_b
  localparam logic [1:0] SRC_B_RT   = 2'd0;
  localparam logic [1:0] SRC_B_SEXT = 2'd1;
  localparam logic [1:0] SRC_B_ZEXT = 2'd2;
  // rf_wsel
  localparam logic [1:0] WSEL_RD   = 2'd0;
  localparam logic [1:0] WSEL_RT   = 2'd1;
  localparam logic [1:0] WSEL_LINK = 2'd2;
  // wb_src
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  // Decoded instruction class. valid=0 marks an unknown encoding (retired as NOP).
  typedef struct packed {
    logic       valid;
    logic       rtype;
    logic       load;
    logic       store;
    logic       branch;
    logic       jump;      // JMP/JAL, resolved in ID
    logic       jump_reg;  // JPR/JRL, resolved in EX
    logic       link;
    logic       wwd;
    logic       hlt;
    logic [1:0] src_b;
    logic [3:0] alu_func;
  } dec_t;

  // ALU comparison code for a branch opcode
  function automatic logic [3:0] branch_alu_func(input logic [3:0] op);
    logic [3:0] f;
    case (op)
      OP_BNE:  f = FUNC_BNE;
      OP_BEQ:  f = FUNC_BEQ;
      OP_BGZ:  f = FUNC_BGZ;
      OP_BLZ:  f = FUNC_BLZ;
      default: f = FUNC_ADD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mc_control_unit_instr_decoder.sv
// Combinational instruction decoder for the control unit.
// Ports:
//   opcode  in  4   instr[15:12]
//   func    in  6   instr[5:0] (meaningful for R-type only)
//   dec     out     class flags, ALU operand-B select and ALU func code
module mc_control_unit_instr_decoder
  import mc_control_unit_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [5:0] func,
  output dec_t       dec
);

  // Opcode/func to instruction class
  always_comb begin
    dec          = '0;
    dec.alu_func = FUNC_ADD;
    dec.src_b    = SRC_B_RT;
    case (opcode)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
        dec.valid    = 1'b1;
        dec.branch   = 1'b1;
        dec.alu_func = branch_alu_func(opcode);
      end
      OP_ADI: begin
        dec.valid = 1'b1;
        dec.src_b = SRC_B_SEXT;
      end
      OP_ORI: begin
        dec.valid    = 1'b1;
        dec.alu_func = FUNC_ORR;
        dec.src_b    = SRC_B_ZEXT;
      end
      OP_LHI: begin
        dec.valid    = 1'b1;
        dec.alu_func = FUNC_LHI;
        dec.src_b    = SRC_B_ZEXT;
      end
      OP_LWD: begin
        dec.valid = 1'b1;
        dec.load  = 1'b1;
        dec.src_b = SRC_B_SEXT;
      end
      OP_SWD: begin
        dec.valid = 1'b1;
        dec.store = 1'b1;
        dec.src_b = SRC_B_SEXT;
      end
      OP_JMP: begin
        dec.valid = 1'b1;
        dec.jump  = 1'b1;
      end
      OP_JAL: begin
        dec.valid = 1'b1;
        dec.jump  = 1'b1;
        dec.link  = 1'b1;
      end
      OP_RTYPE: begin
        case (func)
          INST_FUNC_ADD, INST_FUNC_SUB, INST_FUNC_AND, INST_FUNC_ORR,
          INST_FUNC_NOT, INST_FUNC_TCP, INST_FUNC_SHL, INST_FUNC_SHR: begin
            dec.valid    = 1'b1;
            dec.rtype    = 1'b1;
            // ALU codes 0..7 line up with the arithmetic func field
            dec.alu_func = func[3:0];
          end
          INST_FUNC_JPR: begin
            dec.valid    = 1'b1;
            dec.rtype    = 1'b1;
            dec.jump_reg = 1'b1;
          end
          INST_FUNC_JRL: begin
            dec.valid    = 1'b1;
            dec.rtype    = 1'b1;
            dec.jump_reg = 1'b1;
            dec.link     = 1'b1;
          end
          INST_FUNC_WWD: begin
            dec.valid = 1'b1;
            dec.rtype = 1'b1;
            dec.wwd   = 1'b1;
          end
          INST_FUNC_HLT: begin
            dec.valid = 1'b1;
            dec.rtype = 1'b1;
            dec.hlt   = 1'b1;
          end
          default: dec.valid = 1'b0;
        endcase
      end
      default: dec.valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the 16-bit TSC datapath (IF/ID/EX/MEM/WB/HLT).
// Handshakes with one shared memory port and drives ALU func/operand selects and
// the register-file, PC and IR write enables. Control outputs decode
// combinationally from the state register and the IR; reset forces them all low.
// Ports:
//   clk, reset (async, active high)
//   instr, mem_ready, alu_branch              inputs
//   mem_read, mem_write, i_or_d, ir_write      memory / IR control
//   pc_write, pc_src, alu_func, alu_src_b      PC and ALU control
//   reg_write, rf_wsel, wb_src, wwd, halted    write-back and status
//   num_inst                                   retired-instruction count
// Build option: define CTRL_NUM_INST_EN to enable the num_inst counter;
// otherwise num_inst is tied to zero.
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          instr,
  input  logic                 mem_ready,
  input  logic                 alu_branch,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic [3:0]           alu_func,
  output logic [1:0]           alu_src_b,
  output logic                 reg_write,
  output logic [1:0]           rf_wsel,
  output logic [1:0]           wb_src,
  output logic                 wwd,
  output logic                 halted,
  output logic [WORD_SIZE-1:0] num_inst
);

  state_t state;
  state_t next_state;
  dec_t   dec;

  // Register fields are routed straight to the datapath, not used here
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[11:6];

  mc_control_unit_instr_decoder instr_decoder (
    .opcode (instr[15:12]),
    .func   (instr[5:0]),
    .dec    (dec)
  );

  // Next-state selection
  always_comb begin
    next_state = state;
    case (state)
      S_IF: begin
        if (mem_ready) next_state = S_ID;
        else           next_state = S_IF;
      end
      S_ID: begin
        if (!dec.valid || dec.jump) next_state = S_IF;
        else if (dec.hlt)           next_state = S_HLT;
        else                        next_state = S_EX;
      end
      S_EX: begin
        if (dec.load || dec.store)                     next_state = S_MEM;
        else if (dec.branch || dec.jump_reg || dec.wwd) next_state = S_IF;
        else                                           next_state = S_WB;
      end
      S_MEM: begin
        if (!mem_ready)    next_state = S_MEM;
        else if (dec.load) next_state = S_WB;
        else               next_state = S_IF;
      end
      S_WB:    next_state = S_IF;
      S_HLT:   next_state = S_HLT;
      default: next_state = S_IF;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IF;
    else       state <= next_state;
  end

  // Control output decode; reset overrides so requests drop without waiting
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    i_or_d    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_SRC_SEQ;
    alu_func  = FUNC_ADD;
    alu_src_b = SRC_B_RT;
    reg_write = 1'b0;
    rf_wsel   = WSEL_RD;
    wb_src    = WB_ALU;
    wwd       = 1'b0;
    halted    = 1'b0;
    if (reset) begin
      mem_read = 1'b0;
    end else begin
      case (state)
        S_IF: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
        end
        S_ID: begin
          pc_write = 1'b1;
          if (dec.jump) begin
            pc_src = PC_SRC_JUMP;
            if (dec.link) begin
              reg_write = 1'b1;
              rf_wsel   = WSEL_LINK;
              wb_src    = WB_PC;
            end else begin
              reg_write = 1'b0;
            end
          end else begin
            pc_src = PC_SRC_SEQ;
          end
        end
        S_EX: begin
          alu_func  = dec.alu_func;
          alu_src_b = dec.src_b;
          if (dec.branch) begin
            pc_write = alu_branch;
            pc_src   = alu_branch ? PC_SRC_BRANCH : PC_SRC_SEQ;
          end else if (dec.jump_reg) begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_REG;
            if (dec.link) begin
              reg_write = 1'b1;
              rf_wsel   = WSEL_LINK;
              wb_src    = WB_PC;
            end else begin
              reg_write = 1'b0;
            end
          end else if (dec.wwd) begin
            wwd = 1'b1;
          end else begin
            wwd = 1'b0;
          end
        end
        S_MEM: begin
          i_or_d = 1'b1;
          if (dec.load)       mem_read  = 1'b1;
          else if (dec.store) mem_write = 1'b1;
          else                mem_read  = 1'b0;
        end
        S_WB: begin
          reg_write = 1'b1;
          rf_wsel   = dec.rtype ? WSEL_RD : WSEL_RT;
          wb_src    = dec.load ? WB_MEM : WB_ALU;
        end
        S_HLT:   halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

`ifdef CTRL_NUM_INST_EN
  logic [WORD_SIZE-1:0] count;
  logic                 retire;

  // An instruction retires when the FSM re-enters IF, or when it enters HLT
  assign retire = ((state != S_IF) && (next_state == S_IF)) ||
                  ((state != S_HLT) && (next_state == S_HLT));

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       count <= '0;
    else if (retire) count <= count + {{(WORD_SIZE-1){1'b0}}, 1'b1};
    else             count <= count;
  end

  assign num_inst = count;
`else
  assign num_inst = '0;
`endif

endmodule
